// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID/EX pipeline bundle types.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;

  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Everything the EX stage receives from ID, held as one register.
  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } id_ex_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load sitting in EX.
module hazard_detect
  import mips_pkg::*;
(
  input  logic       valid_d,
  input  logic [5:0] opcode_d,
  input  logic [5:0] funct_d,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       valid_e,
  input  logic       memto_reg_e,
  input  logic       reg_write_e,
  input  logic [4:0] rt_e,
  output logic       uses_rs,
  output logic       uses_rt,
  output logic       lu
);

  // Decode which source registers the ID instruction actually reads.
  always_comb begin
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    case (opcode_d)
      OP_RTYPE: begin
        uses_rt = (funct_d != FN_JR);
        if (funct_d == FN_SLL || funct_d == FN_SRL || funct_d == FN_SRA)
          uses_rs = 1'b0;
      end
      OP_J, OP_JAL: uses_rs = 1'b0;
      OP_BEQ, OP_BNE, OP_SW: uses_rt = 1'b1;
      default: ;
    endcase
  end

  // A load into $zero never creates a dependency.
  always_comb begin
    lu = valid_d && valid_e && memto_reg_e && reg_write_e && (rt_e != 5'd0) &&
         ((uses_rs && (rs_d == rt_e)) || (uses_rt && (rt_d == rt_e)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation and event counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             Valid_D,
  input  logic             RegWrite_D,
  input  logic             MemtoReg_D,
  input  logic             MemWrite_D,
  input  logic             Branch_D,
  input  logic             Jump_D,
  input  logic             ALUSrc_D,
  input  logic             RegDst_D,
  input  logic [5:0]       Opcode_D,
  input  logic [5:0]       Funct_D,
  input  logic [31:0]      regA_data_D,
  input  logic [31:0]      regB_data_D,
  input  logic [31:0]      se_imme_D,
  input  logic [31:0]      PC_add4_D,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [4:0]       rd_D,
  input  logic [4:0]       shamt_D,
  input  logic             Flush_in,
  output logic             Valid_E,
  output logic             RegWrite_E,
  output logic             MemtoReg_E,
  output logic             MemWrite_E,
  output logic             Branch_E,
  output logic             Jump_E,
  output logic             ALUSrc_E,
  output logic             RegDst_E,
  output logic [5:0]       Opcode_E,
  output logic [5:0]       Funct_E,
  output logic [31:0]      regA_data_E,
  output logic [31:0]      regB_data_E,
  output logic [31:0]      se_imme_E,
  output logic [31:0]      PC_add4_E,
  output logic [4:0]       rs_E,
  output logic [4:0]       rt_E,
  output logic [4:0]       rd_E,
  output logic [4:0]       shamt_E,
  output logic             Stall_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  id_ex_t           pipe_d, pipe_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             lu;
  logic             uses_rs;
  logic             uses_rt;
  logic             stall;

  hazard_detect u_hazard (
    .valid_d     (Valid_D),
    .opcode_d    (Opcode_D),
    .funct_d     (Funct_D),
    .rs_d        (rs_D),
    .rt_d        (rt_D),
    .valid_e     (pipe_q.valid),
    .memto_reg_e (pipe_q.ctrl.memto_reg),
    .reg_write_e (pipe_q.ctrl.reg_write),
    .rt_e        (pipe_q.rt),
    .uses_rs     (uses_rs),
    .uses_rt     (uses_rt),
    .lu          (lu)
  );

  // A redirect kills the ID instruction, so it must not also hold it upstream.
  always_comb begin
    stall = lu & ~Flush_in;
  end

  // Next pipeline contents: bubble on flush or stall, else capture ID.
  always_comb begin
    pipe_d             = '0;
    pipe_d.valid       = Valid_D;
    pipe_d.ctrl        = '{RegWrite_D, MemtoReg_D, MemWrite_D, Branch_D,
                           Jump_D, ALUSrc_D, RegDst_D};
    pipe_d.opcode      = Opcode_D;
    pipe_d.funct       = Funct_D;
    pipe_d.rega        = regA_data_D;
    pipe_d.regb        = regB_data_D;
    pipe_d.imm         = se_imme_D;
    pipe_d.pc4         = PC_add4_D;
    pipe_d.rs          = rs_D;
    pipe_d.rt          = rt_D;
    pipe_d.rd          = rd_D;
    pipe_d.shamt       = shamt_D;
    if (Flush_in || stall) begin
      pipe_d      = '0;
      pipe_d.ctrl = CTRL_BUBBLE;
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (Flush_in && Valid_D && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers; reset leaves a bubble in EX.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pipe_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_out   = stall;
  assign Valid_E     = pipe_q.valid;
  assign RegWrite_E  = pipe_q.ctrl.reg_write;
  assign MemtoReg_E  = pipe_q.ctrl.memto_reg;
  assign MemWrite_E  = pipe_q.ctrl.mem_write;
  assign Branch_E    = pipe_q.ctrl.branch;
  assign Jump_E      = pipe_q.ctrl.jump;
  assign ALUSrc_E    = pipe_q.ctrl.alu_src;
  assign RegDst_E    = pipe_q.ctrl.reg_dst;
  assign Opcode_E    = pipe_q.opcode;
  assign Funct_E     = pipe_q.funct;
  assign regA_data_E = pipe_q.rega;
  assign regB_data_E = pipe_q.regb;
  assign se_imme_E   = pipe_q.imm;
  assign PC_add4_E   = pipe_q.pc4;
  assign rs_E        = pipe_q.rs;
  assign rt_E        = pipe_q.rt;
  assign rd_E        = pipe_q.rd;
  assign shamt_E     = pipe_q.shamt;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int CNT_W = 2;

  logic        CLOCK, RESET_N, Valid_D, Flush_in;
  logic        RegWrite_D, MemtoReg_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D, RegDst_D;
  logic [5:0]  Opcode_D, Funct_D;
  logic [31:0] regA_data_D, regB_data_D, se_imme_D, PC_add4_D;
  logic [4:0]  rs_D, rt_D, rd_D, shamt_D;
  logic        Valid_E, RegWrite_E, MemtoReg_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E, RegDst_E;
  logic [5:0]  Opcode_E, Funct_E;
  logic [31:0] regA_data_E, regB_data_E, se_imme_E, PC_add4_E;
  logic [4:0]  rs_E, rt_E, rd_E, shamt_E;
  logic        Stall_out;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .Valid_D(Valid_D),
    .RegWrite_D(RegWrite_D), .MemtoReg_D(MemtoReg_D), .MemWrite_D(MemWrite_D),
    .Branch_D(Branch_D), .Jump_D(Jump_D), .ALUSrc_D(ALUSrc_D), .RegDst_D(RegDst_D),
    .Opcode_D(Opcode_D), .Funct_D(Funct_D), .regA_data_D(regA_data_D),
    .regB_data_D(regB_data_D), .se_imme_D(se_imme_D), .PC_add4_D(PC_add4_D),
    .rs_D(rs_D), .rt_D(rt_D), .rd_D(rd_D), .shamt_D(shamt_D), .Flush_in(Flush_in),
    .Valid_E(Valid_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .MemWrite_E(MemWrite_E), .Branch_E(Branch_E), .Jump_E(Jump_E),
    .ALUSrc_E(ALUSrc_E), .RegDst_E(RegDst_E), .Opcode_E(Opcode_E), .Funct_E(Funct_E),
    .regA_data_E(regA_data_E), .regB_data_E(regB_data_E), .se_imme_E(se_imme_E),
    .PC_add4_E(PC_add4_E), .rs_E(rs_E), .rt_E(rt_E), .rd_E(rd_E), .shamt_E(shamt_E),
    .Stall_out(Stall_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one instruction in ID; ctrl order RegWrite,MemtoReg,MemWrite,Branch,Jump,ALUSrc,RegDst.
  task automatic id_instr(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [6:0] c);
    Valid_D = v; Opcode_D = op; Funct_D = fn;
    rs_D = rs; rt_D = rt; rd_D = rd; shamt_D = sh;
    {RegWrite_D, MemtoReg_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D, RegDst_D} = c;
    regA_data_D = 32'h1111_0000 | {27'd0, rs};
    regB_data_D = 32'h2222_0000 | {27'd0, rt};
    se_imme_D   = 32'h0000_0004;
    PC_add4_D   = 32'h0040_0010;
  endtask

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  // Common instructions.
  task automatic lw_t0;  id_instr(1, OP_LW,    6'h00, 5'd28, 5'd8,  5'd0, 5'd0, 7'b1100010); endtask
  task automatic add_t0; id_instr(1, OP_RTYPE, FN_ADD, 5'd8, 5'd10, 5'd9, 5'd0, 7'b1000001); endtask

  initial begin
    RESET_N = 1'b0; Flush_in = 1'b0;
    id_instr(1, OP_ADDI, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 7'b1000010);
    #2;
    chk("rst_valid_e", Valid_E, 0);
    chk("rst_regwrite_e", RegWrite_E, 0);
    chk("rst_rt_e", rt_E, 0);
    chk("rst_stall", Stall_out, 0);
    #10 RESET_N = 1'b1;
    tick();
    chk("addi_rt_e", rt_E, 8);
    chk("addi_regwrite_e", RegWrite_E, 1);
    // Asynchronous reset mid-cycle clears immediately.
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_rt_e", rt_E, 0);
    chk("async_rst_valid_e", Valid_E, 0);
    chk("async_rst_pc4_e", PC_add4_E, 0);
    #2 RESET_N = 1'b1;
    tick();
    chk("post_rst_rt_e", rt_E, 8);
    chk("post_rst_regwrite_e", RegWrite_E, 1);
    chk("post_rst_alusrc_e", ALUSrc_E, 1);
    chk("post_rst_valid_e", Valid_E, 1);
    chk("post_rst_imm_e", se_imme_E, 4);
    chk("post_rst_stall_cnt", stall_cnt, 0);

    // Load-use: lw $t0 then add $t1,$t0,$t2.
    lw_t0();
    #1 chk("lw_no_stall", Stall_out, 0);
    tick();
    add_t0();
    #1 chk("lu_stall", Stall_out, 1);
    tick();
    chk("lu_bubble_valid", Valid_E, 0);
    chk("lu_bubble_regwrite", RegWrite_E, 0);
    chk("lu_bubble_rd", rd_E, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_stall_cleared", Stall_out, 0);
    tick();
    chk("lu_add_rd_e", rd_E, 9);
    chk("lu_add_rs_e", rs_E, 8);
    chk("lu_add_valid", Valid_E, 1);
    chk("lu_stall_cnt_hold", stall_cnt, 1);

    // No false hazards: sll with rs field = $t0, then load into $zero.
    lw_t0();
    tick();
    id_instr(1, OP_RTYPE, FN_SLL, 5'd8, 5'd10, 5'd9, 5'd2, 7'b1000001);
    #1 chk("sll_no_stall", Stall_out, 0);
    id_instr(1, OP_RTYPE, FN_JR, 5'd31, 5'd8, 5'd0, 5'd0, 7'b0000000);
    #1 chk("jr_rt_no_stall", Stall_out, 0);
    id_instr(0, OP_RTYPE, FN_ADD, 5'd8, 5'd10, 5'd9, 5'd0, 7'b1000001);
    #1 chk("invalid_d_no_stall", Stall_out, 0);
    tick();
    chk("invalid_d_valid_e", Valid_E, 0);
    chk("invalid_d_regwrite_e", RegWrite_E, 1);
    chk("invalid_d_rd_e", rd_E, 9);
    id_instr(1, OP_LW, 6'h00, 5'd28, 5'd0, 5'd0, 5'd0, 7'b1100010);
    tick();
    id_instr(1, OP_RTYPE, FN_ADD, 5'd0, 5'd0, 5'd9, 5'd0, 7'b1000001);
    #1 chk("zero_no_stall", Stall_out, 0);
    tick();

    // Flush beats stall.
    lw_t0();
    tick();
    add_t0();
    Flush_in = 1'b1;
    #1 chk("flush_stall_masked", Stall_out, 0);
    tick();
    Flush_in = 1'b0;
    chk("flush_valid_e", Valid_E, 0);
    chk("flush_rd_e", rd_E, 0);
    chk("flush_regwrite_e", RegWrite_E, 0);
    chk("flush_cnt", flush_cnt, 1);
    chk("flush_stall_cnt", stall_cnt, 1);

    // sw and beq dependencies through rt / rs.
    lw_t0();
    tick();
    id_instr(1, OP_SW, 6'h00, 5'd29, 5'd8, 5'd0, 5'd0, 7'b0010010);
    #1 chk("sw_stall", Stall_out, 1);
    tick();
    chk("sw_bubble_valid", Valid_E, 0);
    chk("sw_stall_cnt", stall_cnt, 2);
    tick();
    chk("sw_memwrite_e", MemWrite_E, 1);
    lw_t0();
    tick();
    id_instr(1, OP_BEQ, 6'h00, 5'd8, 5'd9, 5'd0, 5'd0, 7'b0001000);
    #1 chk("beq_stall", Stall_out, 1);
    tick();
    chk("beq_stall_cnt", stall_cnt, 3);
    tick();
    chk("beq_branch_e", Branch_E, 1);

    // Saturation with a 2-bit counter: 1,2,3,3,3.
    RESET_N = 1'b0;
    #1 RESET_N = 1'b1;
    chk("sat_start", stall_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      lw_t0();
      tick();
      add_t0();
      #1 chk("sat_stall", Stall_out, 1);
      tick();
      chk("sat_cnt", stall_cnt, (i < 3) ? i + 1 : 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the decode stage (IF/ID register, control unit, register file, sign extension) and feeds the execute stage. It latches decoded control, operands and register addresses each cycle. It also owns load-use hazard detection: it drives the stall request back to the PC and IF/ID register and inserts a bubble into EX. Saturating counters record stall and flush events for performance inspection.

Parameters:
CNT_W, 16, width of the stall and flush event counters (saturating)

Ports:
CLOCK  in  1  pipeline clock; all state updates on rising edge
RESET_N  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
Valid_D  in  1  ID holds a real instruction (0 after IF/ID flush)
RegWrite_D, MemtoReg_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D, RegDst_D  in  1 each  decoded control
Opcode_D, Funct_D  in  6 each  instruction opcode / funct
regA_data_D, regB_data_D  in  32 each  register-file read data
se_imme_D  in  32  sign-extended immediate
PC_add4_D  in  32  PC+4 of the ID instruction
rs_D, rt_D, rd_D, shamt_D  in  5 each  instruction fields
Flush_in  in  1  branch/jump redirect from EX; kill the ID instruction
*_E outputs  out  same widths  registered copies of every *_D input above, plus Valid_E
Stall_out  out  1  combinational; freezes PC and IF/ID this cycle
stall_cnt, flush_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (RESET_N=0, asynchronous): all *_E outputs, Valid_E, stall_cnt and flush_cnt go to 0 at once. Stall_out=0 while in reset. Released state is a bubble.
- Source-usage decode from Opcode_D/Funct_D:
  - uses_rs = 0 for j, jal, sll, srl, sra; 1 otherwise.
  - uses_rt = 1 for R-type except jr, and for beq, bne, sw; 0 otherwise.
- Load-use hazard. lu = all of the following:
  - Valid_E, MemtoReg_E and RegWrite_E are 1;
  - rt_E != 0;
  - (uses_rs and rs_D==rt_E) or (uses_rt and rt_D==rt_E);
  - Valid_D is 1.
- Stall_out = lu & ~Flush_in. Pure combinational; zero register latency.
- Register update each rising edge, priority order:
  1. Flush_in=1 -> bubble: all control outputs, Valid_E and all data/address outputs load 0. Flush beats stall.
  2. Stall_out=1 -> bubble is loaded identically. The ID instruction is held upstream and re-presented next cycle.
  3. Otherwise -> every *_E output loads its *_D input; Valid_E loads Valid_D.
- Hazard self-clears: after one bubble, EX no longer holds the load, so Stall_out lasts exactly 1 cycle per load-use pair. Back-to-back dependent loads each stall once.
- An instruction with Valid_D=0 never raises a stall and is passed through as invalid, with controls as supplied.
- Counters:
  - stall_cnt increments on each edge where Stall_out=1.
  - flush_cnt increments on each edge where Flush_in=1 and Valid_D=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-stall: asynchronous clear wins immediately. The first post-reset edge captures the ID inputs normally.
- Timing: no combinational path from Flush_in to any *_E output. Only Stall_out is combinational.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI ...);
  - funct constants (FN_SLL, FN_SRL, FN_SRA, FN_JR ...);
  - typedef ctrl_t bundling the seven control bits;
  - constant CTRL_BUBBLE = all zero.
- Sub-module hazard_detect: purely combinational. It computes uses_rs/uses_rt and lu. It is reusable by a later forwarding unit.

Test Plan:
- Reset: hold RESET_N=0 mid-cycle with Valid_D=1 -> all outputs 0 immediately. The first edge after release captures addi $t0 (rt_E=8, RegWrite_E=1, ALUSrc_E=1).
- Load-use: lw $t0,0($gp) in EX, then add $t1,$t0,$t2 in ID (rs_D=8) -> Stall_out=1 for exactly 1 cycle. Next edge loads a bubble (Valid_E=0, RegWrite_E=0); the add is captured on the following edge; stall_cnt=1.
- No false hazard:
  - lw to $t0 in EX, sll $t1,$t2,2 in ID with rs_D field=8 -> Stall_out=0;
  - lw to $zero in EX, add using $0 -> Stall_out=0.
- Flush priority: assert Flush_in together with a load-use condition -> Stall_out=0, bubble loaded, flush_cnt=1, stall_cnt unchanged.
- sw dependency: lw $t0 in EX, sw $t0,4($sp) in ID (rt_D=8) -> stall 1 cycle. beq $t0,$t1 likewise stalls.
- Saturation: CNT_W=2, force 5 consecutive stall events -> stall_cnt reads 3 and stays at 3.
